// File: rtl/running_extreme_pipelined.sv
// Sliding-window max/min finder: DEPTH-entry sample window feeding a registered
// binary comparison tree that reports the extreme's value, age and the fill count.
module running_extreme_pipelined #(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 8,
    parameter  int SIGNED = 0,
    localparam int IW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             clear,
    input  logic             mode,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_value,
    output logic [IW-1:0]    out_index,
    output logic [CW-1:0]    out_count
);

    localparam int L = IW;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] value;
        logic [IW-1:0]    index;
    } node_t;

    logic             mode_q, mode_d;
    logic [CW-1:0]    count_q, count_d;
    logic [DEPTH-1:0] win_valid_q, win_valid_d;
    logic [WIDTH-1:0] win_data_q [DEPTH];
    logic [WIDTH-1:0] win_data_d [DEPTH];
    node_t            tree_q [1:DEPTH-1];
    node_t            tree_d [1:DEPTH-1];
    logic [L:0]       pv_q, pv_d;
    logic [WIDTH-1:0] hold_value_q, hold_value_d;
    logic [IW-1:0]    hold_index_q, hold_index_d;

    // Heap view: node 1 is the root, nodes DEPTH..2*DEPTH-1 are window slots 0..DEPTH-1.
    node_t node [1:2*DEPTH-1];

    logic accept;
    assign accept = in_valid & ~clear;

    // Ties go to a (the lower-slot, newer child); sign-extend only when SIGNED.
    function automatic node_t pick(input node_t a, input node_t b, input logic use_min);
        logic signed [WIDTH:0] ea, eb;
        logic a_wins;
        ea = {(SIGNED != 0) & a.value[WIDTH-1], a.value};
        eb = {(SIGNED != 0) & b.value[WIDTH-1], b.value};
        a_wins = use_min ? (ea <= eb) : (ea >= eb);
        if (!b.valid) return a;
        if (!a.valid) return b;
        return a_wins ? a : b;
    endfunction

    always_comb begin
        for (int n = 1; n < DEPTH; n++) node[n] = tree_q[n];
        for (int s = 0; s < DEPTH; s++) begin
            node[DEPTH+s] = '{valid: win_valid_q[s], value: win_data_q[s], index: IW'(s)};
        end
    end

    always_comb begin
        mode_d       = mode_q;
        count_d      = count_q;
        win_valid_d  = win_valid_q;
        win_data_d   = win_data_q;
        pv_d         = {pv_q[L-1:0], accept};
        hold_value_d = hold_value_q;
        hold_index_d = hold_index_q;
        for (int n = 1; n < DEPTH; n++) tree_d[n] = pick(node[2*n], node[2*n+1], mode_q);

        if (pv_q[L]) begin
            hold_value_d = node[1].value;
            hold_index_d = node[1].index;
        end

        if (clear) begin
            mode_d       = mode;
            count_d      = '0;
            win_valid_d  = '0;
            pv_d         = '0;
            hold_value_d = '0;
            hold_index_d = '0;
            for (int n = 1; n < DEPTH; n++) tree_d[n] = '0;
        end else if (accept) begin
            win_valid_d = {win_valid_q[DEPTH-2:0], 1'b1};
            for (int s = DEPTH - 1; s > 0; s--) win_data_d[s] = win_data_q[s-1];
            win_data_d[0] = data_in;
            if (count_q != CW'(DEPTH)) count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q       <= 1'b0;
            count_q      <= '0;
            win_valid_q  <= '0;
            pv_q         <= '0;
            hold_value_q <= '0;
            hold_index_q <= '0;
            // NOTE: window data is reset along with the valids so a flushed
            // window never exposes stale samples through the tree's value fields.
            for (int s = 0; s < DEPTH; s++) win_data_q[s] <= '0;
            for (int n = 1; n < DEPTH; n++) tree_q[n] <= '0;
        end else begin
            mode_q       <= mode_d;
            count_q      <= count_d;
            win_valid_q  <= win_valid_d;
            win_data_q   <= win_data_d;
            pv_q         <= pv_d;
            hold_value_q <= hold_value_d;
            hold_index_q <= hold_index_d;
            tree_q       <= tree_d;
        end
    end

    assign out_valid = pv_q[L];
    assign out_value = pv_q[L] ? node[1].value : hold_value_q;
    assign out_index = pv_q[L] ? node[1].index : hold_index_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_running_extreme_pipelined.sv
// Directed bench for running_extreme_pipelined: a vector table for fill/slide, min,
// ties, reset and gapped input, plus hand sequences for mid-flight flush and signed compare.
module tb_running_extreme_pipelined;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] data_in = '0;
    logic       clear = 1'b0;
    logic       mode = 1'b0;

    logic       u_valid, s_valid;
    logic [7:0] u_value, s_value;
    logic [2:0] u_index, s_index;
    logic [3:0] u_count, s_count;

    int errors = 0;
    int checks = 0;

    running_extreme_pipelined #(.WIDTH(8), .DEPTH(8), .SIGNED(0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in),
        .clear(clear), .mode(mode), .out_valid(u_valid), .out_value(u_value),
        .out_index(u_index), .out_count(u_count)
    );

    running_extreme_pipelined #(.WIDTH(8), .DEPTH(8), .SIGNED(1)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in),
        .clear(clear), .mode(mode), .out_valid(s_valid), .out_value(s_value),
        .out_index(s_index), .out_count(s_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       rst, clr, md, vld;
        logic [7:0] din;
        logic       exp_valid;
        logic [7:0] exp_value;
        logic [2:0] exp_index;
        logic [3:0] exp_count;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string tag, input logic rst, input logic clr,
                                input logic md, input logic vld, input logic [7:0] din,
                                input logic ev, input logic [7:0] evalue,
                                input logic [2:0] eidx, input logic [3:0] ecnt);
        vec_t v;
        v.tag = tag; v.rst = rst; v.clr = clr; v.md = md; v.vld = vld; v.din = din;
        v.exp_valid = ev; v.exp_value = evalue; v.exp_index = eidx; v.exp_count = ecnt;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the consuming edge.
    task automatic step(input logic r, input logic c, input logic m, input logic v,
                        input logic [7:0] d);
        @(negedge clk);
        reset = r; clear = c; mode = m; in_valid = v; data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;

        //    tag      rst clr md vld din   ev val idx cnt
        add("reset", 1, 0, 0, 0, 8'd0,  0, 0, 0, 0);
        add("fill",  0, 0, 0, 1, 8'd3,  0, 0, 0, 1);
        add("fill",  0, 0, 0, 1, 8'd9,  0, 0, 0, 2);
        add("fill",  0, 0, 0, 1, 8'd2,  0, 0, 0, 3);
        add("fill",  0, 0, 0, 1, 8'd7,  1, 3, 0, 4);
        add("fill",  0, 0, 0, 1, 8'd1,  1, 9, 0, 5);
        add("fill",  0, 0, 0, 1, 8'd1,  1, 9, 1, 6);
        add("fill",  0, 0, 0, 1, 8'd1,  1, 9, 2, 7);
        add("fill",  0, 0, 0, 1, 8'd1,  1, 9, 3, 8);
        add("fill",  0, 0, 0, 1, 8'd1,  1, 9, 4, 8);
        add("fill",  0, 0, 0, 1, 8'd1,  1, 9, 5, 8);
        add("fill",  0, 0, 0, 0, 8'd0,  1, 9, 6, 8);
        add("fill",  0, 0, 0, 0, 8'd0,  1, 9, 7, 8);
        add("fill",  0, 0, 0, 0, 8'd0,  1, 7, 6, 8);
        add("hold",  0, 0, 0, 0, 8'd0,  0, 7, 6, 8);
        add("min",   0, 1, 1, 1, 8'd0,  0, 0, 0, 0);
        add("min",   0, 0, 0, 1, 8'd5,  0, 0, 0, 1);
        add("min",   0, 0, 0, 1, 8'd2,  0, 0, 0, 2);
        add("min",   0, 0, 0, 1, 8'd8,  0, 0, 0, 3);
        add("min",   0, 0, 0, 0, 8'd0,  1, 5, 0, 3);
        add("min",   0, 0, 0, 0, 8'd0,  1, 2, 0, 3);
        add("min",   0, 0, 0, 0, 8'd0,  1, 2, 1, 3);
        add("min",   0, 0, 0, 0, 8'd0,  0, 2, 1, 3);
        add("rstmd", 1, 0, 1, 1, 8'h55, 0, 0, 0, 0);
        add("rstmd", 0, 0, 1, 1, 8'd5,  0, 0, 0, 1);
        add("rstmd", 0, 0, 1, 1, 8'd9,  0, 0, 0, 2);
        add("rstmd", 0, 0, 1, 0, 8'd0,  0, 0, 0, 2);
        add("rstmd", 0, 0, 1, 0, 8'd0,  1, 5, 0, 2);
        add("rstmd", 0, 0, 1, 0, 8'd0,  1, 9, 0, 2);
        add("ties",  0, 1, 0, 0, 8'd0,  0, 0, 0, 0);
        add("ties",  0, 0, 0, 1, 8'd4,  0, 0, 0, 1);
        add("ties",  0, 0, 0, 1, 8'd4,  0, 0, 0, 2);
        add("ties",  0, 0, 0, 1, 8'd4,  0, 0, 0, 3);
        add("ties",  0, 0, 0, 0, 8'd0,  1, 4, 0, 3);
        add("ties",  0, 0, 0, 0, 8'd0,  1, 4, 0, 3);
        add("ties",  0, 0, 0, 0, 8'd0,  1, 4, 0, 3);
        add("gap",   0, 1, 0, 0, 8'd0,  0, 0, 0, 0);
        add("gap",   0, 0, 0, 1, 8'd1,  0, 0, 0, 1);
        add("gap",   0, 0, 0, 0, 8'd0,  0, 0, 0, 1);
        add("gap",   0, 0, 0, 0, 8'd0,  0, 0, 0, 1);
        add("gap",   0, 0, 0, 1, 8'd2,  1, 1, 0, 2);
        add("gap",   0, 0, 0, 0, 8'd0,  0, 1, 0, 2);
        add("gap",   0, 0, 0, 0, 8'd0,  0, 1, 0, 2);
        add("gap",   0, 0, 0, 1, 8'd3,  1, 2, 0, 3);
        add("gap",   0, 0, 0, 0, 8'd0,  0, 2, 0, 3);
        add("gap",   0, 0, 0, 0, 8'd0,  0, 2, 0, 3);
        add("gap",   0, 0, 0, 0, 8'd0,  1, 3, 0, 3);
        add("gap",   0, 0, 0, 1, 8'd0,  0, 3, 0, 4);
        add("gap",   0, 0, 0, 0, 8'd0,  0, 3, 0, 4);
        add("gap",   0, 0, 0, 0, 8'd0,  0, 3, 0, 4);
        add("gap",   0, 0, 0, 0, 8'd0,  1, 3, 1, 4);
        add("gap",   0, 0, 0, 0, 8'd0,  0, 3, 1, 4);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].clr, vecs[i].md, vecs[i].vld, vecs[i].din);
            check($sformatf("%s[%0d].valid", vecs[i].tag, i), 32'(u_valid), 32'(vecs[i].exp_valid));
            check($sformatf("%s[%0d].value", vecs[i].tag, i), 32'(u_value), 32'(vecs[i].exp_value));
            check($sformatf("%s[%0d].index", vecs[i].tag, i), 32'(u_index), 32'(vecs[i].exp_index));
            check($sformatf("%s[%0d].count", vecs[i].tag, i), 32'(u_count), 32'(vecs[i].exp_count));
        end

        // Flush mid-flight: clear right after the sixth accept kills all in-flight results.
        step(0, 1, 0, 0, 8'd0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 8'(10 + i));
        step(0, 1, 0, 0, 8'd0);
        check("flush.count", 32'(u_count), 32'd0);
        check("flush.value", 32'(u_value), 32'd0);
        pulses = int'(u_valid);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 8'd0);
            pulses += int'(u_valid);
        end
        check("flush.pulses", 32'(pulses), 32'd0);
        step(0, 0, 0, 1, 8'd1);
        check("flush.count1", 32'(u_count), 32'd1);
        step(0, 0, 0, 0, 8'd0);
        step(0, 0, 0, 0, 8'd0);
        step(0, 0, 0, 0, 8'd0);
        check("flush.valid", 32'(u_valid), 32'd1);
        check("flush.value1", 32'(u_value), 32'd1);
        check("flush.index", 32'(u_index), 32'd0);

        // Signed vs unsigned: 0xF0 then 0x05, in max mode then in min mode.
        for (int m = 0; m < 2; m++) begin
            step(0, 1, m[0], 0, 8'd0);
            step(0, 0, 0, 1, 8'hF0);
            step(0, 0, 0, 1, 8'h05);
            step(0, 0, 0, 0, 8'd0);
            step(0, 0, 0, 0, 8'd0);
            check($sformatf("signed%0d.a.valid", m), 32'(s_valid), 32'd1);
            check($sformatf("signed%0d.a.value", m), 32'(s_value), 32'hF0);
            check($sformatf("signed%0d.a.index", m), 32'(s_index), 32'd0);
            check($sformatf("unsigned%0d.a.value", m), 32'(u_value), 32'hF0);
            step(0, 0, 0, 0, 8'd0);
            check($sformatf("signed%0d.b.valid", m), 32'(s_valid), 32'd1);
            check($sformatf("signed%0d.b.value", m), 32'(s_value), (m == 0) ? 32'h05 : 32'hF0);
            check($sformatf("signed%0d.b.index", m), 32'(s_index), (m == 0) ? 32'd0 : 32'd1);
            check($sformatf("unsigned%0d.b.value", m), 32'(u_value), (m == 0) ? 32'hF0 : 32'h05);
            check($sformatf("unsigned%0d.b.index", m), 32'(u_index), (m == 0) ? 32'd1 : 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/running_extreme_pipelined.md
# running_extreme_pipelined

Parametrised successor to the fixed 8×4-bit running-high finder. Tracks the maximum or minimum of the last DEPTH accepted samples through a registered comparison tree. Adds a valid-qualified input, per-slot occupancy, run-time max/min mode, synchronous window clear, and signed support. Reports the extreme's value, its age in the window and the window fill count. Sits in the streaming datapath wherever a sliding-window peak or trough is needed.

## Interface
- WIDTH, 8, sample width in bits (≥1)
- DEPTH, 8, window length; power of two, ≥2
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high; clears window, pipeline and mode
- in_valid  input  1  data_in accepted on this edge when high
- data_in  input  WIDTH  sample
- clear  input  1  synchronous window flush; also loads mode
- mode  input  1  0 = max, 1 = min; sampled only on reset (forced 0) or clear
- out_valid  output  1  one-cycle pulse per accepted sample
- out_value  output  WIDTH  extreme of window
- out_index  output  $clog2(DEPTH)  age of extreme; 0 = newest sample
- out_count  output  $clog2(DEPTH+1)  valid entries in window, saturates at DEPTH

## Operation
- Window: DEPTH-entry shift register, each entry carrying {valid, data}.
  - On accept (in_valid=1, clear=0, reset=0), data_in enters slot 0 with valid=1.
  - All entries move one slot older; slot DEPTH-1 is discarded.
  - No shift when in_valid=0.
- Occupancy: out_count increments per accept until it reaches DEPTH, then holds.
- Tree: L = log2(DEPTH) registered levels. Each node combines two children into {valid, value, index}.
  - One child invalid → take the other child.
  - Both children invalid → result invalid.
  - Both valid → keep the larger value (mode=0) or smaller value (mode=1).
  - Tie → keep the newer child (smaller index).
- Index: index carries slot age. Widths are unchanged through the tree; no arithmetic overflow is possible.
- Compare type: SIGNED=1 compares as $signed, otherwise unsigned.
- Mode register: loaded from mode on a clear cycle; forced to 0 on reset. The mode register is the only mode source used by the tree.
- Pipeline valid: a one-bit valid travels alongside the tree. out_valid is that bit at the last level.
- Clear: has priority over in_valid; a sample presented in the same cycle is dropped. Clear takes effect on the next edge:
  - all window valids → 0
  - all tree and pipeline valids → 0, so in-flight results never emit
  - out_count → 0
- Reset: same effect as clear, and mode register → 0.
  - Reset values: out_valid=0, out_value=0, out_index=0, out_count=0.
- Hold: out_value and out_index hold their last values while out_valid=0. Clear and reset zero them.

## Timing
- Latency: a sample accepted in cycle k produces out_valid=1 in cycle k+1+L (k+4 for DEPTH=8). That result reflects the window including that sample.
- Throughput: one result per cycle under back-to-back in_valid. Gaps in in_valid produce matching gaps in out_valid.
- out_count is updated one cycle after acceptance (cycle k+1). It is not aligned to out_valid.
- Mode: a mode change via clear applies to every sample accepted after the clear.
- Reset or clear asserted mid-stream: out_valid=0 from the next cycle. The next accepted sample yields a single-entry window result (index 0).

## Test plan
- Fill and slide, DEPTH=8, WIDTH=8, mode=0, back-to-back input 3,9,2,7,1,1,1,1,1,1:
  - out_value: 3,9,9,9,9,9,9,9,9,7
  - out_index: 0,0,1,2,3,4,5,6,7,6
  - out_count saturates at 8
  - first out_valid appears 4 cycles after the first accept
- Min via clear: clear with mode=1, then input 5,2,8 → out_value 5,2,2, out_index 0,0,1. A sample driven in the clear cycle produces no output.
- Ties: mode=0, input 4,4,4 → out_value 4, out_index 0 every time (newest wins).
- Signed: SIGNED=1, WIDTH=8, input 0xF0 (−16), then 0x05:
  - max mode → 0xF0, then 0x05
  - min mode after clear → 0xF0 twice
- Flush mid-flight: accept 6 samples, assert clear the cycle after the last accept → zero out_valid pulses for the in-flight samples; out_count=0. The next sample 1 → out_value 1, out_index 0, out_count 1.
- Gapped input: in_valid every third cycle, values 1,2,3 → exactly three out_valid pulses, each 4 cycles after its accept; the window does not shift on idle cycles.
